hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Hazard and pipeline-sequencing controller for the 5-stage ARM pipeline.
//  Drives the forwarding muxes plus the stall and flush controls of the F/D/E/M/W pipeline registers.
//  Resolves three hazard classes: RAW by forwarding, load-use by stalling, and PC writes/branches by flushing.
//  Adds a multi-cycle data-memory wait FSM with timeout, which freezes F..M and bubbles W.
// PARAMETERS
//  MEM_TIMEOUT  255  max consecutive wait cycles before MemErr (1..65535)
//  CNT_W        16   perf counter width (used only with HAZARD_PERF_CNT_EN)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   async, active-low (0 = reset)
//  Match_1E_M   in   1   RA1E==WA3M
//  Match_1E_W   in   1   RA1E==WA3W
//  Match_2E_M   in   1   RA2E==WA3M
//  Match_2E_W   in   1   RA2E==WA3W
//  Match_12D_E  in   1   RA1D or RA2D ==WA3E
//  RegWriteE/M/W in  1   regfile write pending in E/M/W (3 ports)
//  MemtoRegE    in   1   E-stage instruction is a load
//  PCSrcD/E/M/W in   1   PC-writing instruction in D/E/M/W (4 ports)
//  BranchTakenE in   1   branch resolved taken in E
//  MemReqM      in   1   load/store active in M
//  MemReadyM    in   1   data memory completes access this cycle
//  ForwardAE    out  2   00 regfile, 01 ResultW, 10 ALUOutM
//  ForwardBE    out  2   same encoding, SrcB
//  StallF,StallD,StallE,StallM out 1  hold stage register (1 = hold)
//  FlushD,FlushE,FlushW out 1  clear stage register to bubble
//  MemErr       out  1   sticky memory-timeout error
// BEHAVIOUR
//  Forwarding (combinational):
//   ForwardAE = 10 if Match_1E_M&RegWriteM; else 01 if Match_1E_W&RegWriteW; else 00.
//   M has priority over W. ForwardBE is identical using Match_2E_*.
//  Internal terms:
//   ldrStall = Match_12D_E & MemtoRegE & RegWriteE
//   pcPend   = PCSrcD|PCSrcE|PCSrcM
//   memWait  = (state==WAIT) | (state==RUN & MemReqM & ~MemReadyM), or state==ERR
//  memWait=1 (overrides everything):
//   StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
//  memWait=0:
//   StallF = ldrStall|pcPend; StallD = ldrStall; StallE=StallM=FlushW=0
//   FlushD = pcPend|PCSrcW|BranchTakenE; FlushE = ldrStall|BranchTakenE
//  FSM states: RUN, WAIT, ERR. Wait counter wcnt is 16 bits.
//   RUN : if MemReqM&~MemReadyM -> WAIT with wcnt=1; else stay.
//   WAIT: if MemReadyM -> RUN and wcnt=0 (that cycle still stalls; release next cycle).
//         else if wcnt==MEM_TIMEOUT -> ERR with MemErr<=1; else wcnt+1.
//   ERR : absorbing until reset. Pipeline stays frozen. MemErr=1.
//  MemReadyM in the same cycle as MemReqM in RUN: zero-wait access, no stall.
//  Ready and timeout in the same cycle: ready wins -> RUN.
//  Reset (async assert, sync release): state=RUN, wcnt=0, MemErr=0, counters=0.
//   Comb outputs follow their inputs. Reset mid-WAIT/ERR returns immediately to RUN.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//   Adds outputs StallCnt, FlushCnt [CNT_W-1:0].
//   StallCnt +1 each cycle StallD=1. FlushCnt +1 each cycle FlushD|FlushE=1.
//   Both saturate at all-ones and reset to 0.
//  Undefined: ports and logic are absent. Hazard behaviour is otherwise identical.
// TESTING
//  T1: Match_1E_M=Match_1E_W=1, RegWriteM=RegWriteW=1 -> ForwardAE=10.
//      Same with RegWriteM=0 -> 01. Both RegWrite=0 -> 00.
//  T2: Match_12D_E=MemtoRegE=RegWriteE=1 -> StallF=StallD=FlushE=1, FlushD=0 for 1 cycle.
//  T3: BranchTakenE=1 -> FlushD=FlushE=1, StallF=0.
//      PCSrcD=1 -> StallF=1, FlushD=1 until PCSrcW.
//  T4: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF..M=1 and FlushW=1 for 4 cycles.
//      State returns to RUN, and stalls drop on cycle 5.
//  T5: MEM_TIMEOUT=4, MemReadyM held 0 -> MemErr=1 after cycle 5, stalls stay 1.
//      reset=0 -> MemErr=0, state RUN.
//  T6 (HAZARD_PERF_CNT_EN): CNT_W=4, 20 load-use stalls -> StallCnt=15 (saturated).

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding, load-use stalls, PC flushes and a data-memory wait FSM.
// Optional perf counters (StallCnt/FlushCnt) exist only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Match_1E_M,
  input  logic             Match_1E_W,
  input  logic             Match_2E_M,
  input  logic             Match_2E_W,
  input  logic             Match_12D_E,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ERR} state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(MEM_TIMEOUT);

  state_t      state, next_state;
  logic [15:0] wcnt, next_wcnt;
  logic        set_err;
  logic        ldr_stall, pc_pend, mem_wait;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_RUN;
      wcnt   <= '0;
      MemErr <= 1'b0;
    end else begin
      state  <= next_state;
      wcnt   <= next_wcnt;
      MemErr <= MemErr | set_err;
    end
  end

  // Ready is checked before the timeout so a completion on the last allowed cycle is not an error.
  always_comb begin
    next_state = state;
    next_wcnt  = wcnt;
    set_err    = 1'b0;
    case (state)
      ST_RUN: begin
        if (MemReqM && !MemReadyM) begin
          next_state = ST_WAIT;
          next_wcnt  = 16'd1;
        end
      end
      ST_WAIT: begin
        if (MemReadyM) begin
          next_state = ST_RUN;
          next_wcnt  = '0;
        end else if (wcnt == TIMEOUT_W) begin
          next_state = ST_ERR;
          set_err    = 1'b1;
        end else begin
          next_wcnt = wcnt + 16'd1;
        end
      end
      ST_ERR:  next_state = ST_ERR;
      default: begin
        next_state = ST_RUN;
        next_wcnt  = '0;
      end
    endcase
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (Match_1E_M && RegWriteM)      ForwardAE = 2'b10;
    else if (Match_1E_W && RegWriteW) ForwardAE = 2'b01;
    if (Match_2E_M && RegWriteM)      ForwardBE = 2'b10;
    else if (Match_2E_W && RegWriteW) ForwardBE = 2'b01;

    ldr_stall = Match_12D_E & MemtoRegE & RegWriteE;
    pc_pend   = PCSrcD | PCSrcE | PCSrcM;
    mem_wait  = (state == ST_WAIT) || (state == ST_ERR) ||
                ((state == ST_RUN) && MemReqM && !MemReadyM);

    // A memory wait freezes F..M and bubbles W, overriding every other hazard.
    if (mem_wait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end else begin
      StallF = ldr_stall | pc_pend;
      StallD = ldr_stall;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = pc_pend | PCSrcW | BranchTakenE;
      FlushE = ldr_stall | BranchTakenE;
      FlushW = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallD && (StallCnt != '1))
        StallCnt <= StallCnt + CNT_W'(1);
      if ((FlushD || FlushE) && (FlushCnt != '1))
        FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4; CNT_W=4 when HAZARD_PERF_CNT_EN is defined).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic       MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
`ifdef HAZARD_PERF_CNT_EN
  logic [3:0] StallCnt, FlushCnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Control vector order: StallF StallD StallE StallM FlushD FlushE FlushW
  wire [6:0] ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MEM_TIMEOUT(4),
`ifdef HAZARD_PERF_CNT_EN
    .CNT_W(4)
`else
    .CNT_W(16)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  task automatic clear_inputs();
    {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = '0;
    {MemReqM, MemReadyM} = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    #2;
    vectors++;
    if (MemErr !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_memerr: got %b expected 0", MemErr);
    end
    vectors++;
    if (ctrl !== 7'b0000000) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000", ctrl);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_forwarding();
    logic [5:0] stim [6];
    logic [3:0] exp  [6];
    // stim = {Match_xE_M, Match_xE_W, RegWriteM, RegWriteW, use_portB, -}; exp = {ForwardAE, ForwardBE}
    stim[0] = 6'b111100; exp[0] = 4'b1000;
    stim[1] = 6'b110100; exp[1] = 4'b0100;
    stim[2] = 6'b110000; exp[2] = 4'b0000;
    stim[3] = 6'b101000; exp[3] = 4'b1000;
    stim[4] = 6'b111110; exp[4] = 4'b0010;
    stim[5] = 6'b011110; exp[5] = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clear_inputs();
      RegWriteM = stim[i][3];
      RegWriteW = stim[i][2];
      if (stim[i][1]) begin
        Match_2E_M = stim[i][5];
        Match_2E_W = stim[i][4];
      end else begin
        Match_1E_M = stim[i][5];
        Match_1E_W = stim[i][4];
      end
      #2;
      vectors++;
      if ({ForwardAE, ForwardBE} !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL forward_%0d: got A=%b B=%b expected A=%b B=%b",
                 i, ForwardAE, ForwardBE, exp[i][3:2], exp[i][1:0]);
      end
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    Match_12D_E = 1'b1; MemtoRegE = 1'b1; RegWriteE = 1'b1;
    #2;
    vectors++;
    if (ctrl !== 7'b1100010) begin
      miscompares++;
      $display("[TB] FAIL load_use: got %b expected 1100010", ctrl);
    end
    @(negedge clk);
    RegWriteE = 1'b0;
    #2;
    vectors++;
    if (ctrl !== 7'b0000000) begin
      miscompares++;
      $display("[TB] FAIL load_use_nowrite: got %b expected 0000000", ctrl);
    end
  endtask

  task automatic test_branch_flush();
    logic [4:0] stim [6];
    logic [6:0] exp  [6];
    // stim = {BranchTakenE, PCSrcD, PCSrcE, PCSrcM, PCSrcW}
    stim[0] = 5'b10000; exp[0] = 7'b0000110;
    stim[1] = 5'b01000; exp[1] = 7'b1000100;
    stim[2] = 5'b00100; exp[2] = 7'b1000100;
    stim[3] = 5'b00010; exp[3] = 7'b1000100;
    stim[4] = 5'b00001; exp[4] = 7'b0000100;
    stim[5] = 5'b00000; exp[5] = 7'b0000000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clear_inputs();
      {BranchTakenE, PCSrcD, PCSrcE, PCSrcM, PCSrcW} = stim[i];
      #2;
      vectors++;
      if (ctrl !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL branch_flush_%0d: got %b expected %b", i, ctrl, exp[i]);
      end
    end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear_inputs();
      BranchTakenE = 1'b1;
      MemReqM = 1'b1;
      MemReadyM = (i == 3);
      #2;
      vectors++;
      if (ctrl !== 7'b1111001) begin
        miscompares++;
        $display("[TB] FAIL mem_wait_cycle%0d: got %b expected 1111001", i + 1, ctrl);
      end
    end
    @(negedge clk);
    clear_inputs();
    #2;
    vectors++;
    if (ctrl !== 7'b0000000) begin
      miscompares++;
      $display("[TB] FAIL mem_wait_release: got %b expected 0000000", ctrl);
    end
    @(negedge clk);
    MemReqM = 1'b1; MemReadyM = 1'b1;
    #2;
    vectors++;
    if (ctrl !== 7'b0000000) begin
      miscompares++;
      $display("[TB] FAIL zero_wait: got %b expected 0000000", ctrl);
    end
  endtask

  task automatic test_ready_at_timeout();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear_inputs();
      MemReqM = 1'b1;
    end
    @(negedge clk);
    MemReadyM = 1'b1;
    #2;
    vectors++;
    if (ctrl !== 7'b1111001) begin
      miscompares++;
      $display("[TB] FAIL ready_timeout_stall: got %b expected 1111001", ctrl);
    end
    @(negedge clk);
    clear_inputs();
    #2;
    vectors++;
    if ({MemErr, ctrl} !== 8'b00000000) begin
      miscompares++;
      $display("[TB] FAIL ready_timeout_run: got err=%b ctrl=%b expected err=0 ctrl=0000000", MemErr, ctrl);
    end
  endtask

  task automatic test_timeout_err();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      clear_inputs();
      MemReqM = 1'b1;
      #2;
      vectors++;
      if (MemErr !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL timeout_early_cycle%0d: got %b expected 0", i + 1, MemErr);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      MemReadyM = (i == 1);
      #2;
      vectors++;
      if ({MemErr, ctrl} !== 8'b11111001) begin
        miscompares++;
        $display("[TB] FAIL timeout_err_%0d: got err=%b ctrl=%b expected err=1 ctrl=1111001", i, MemErr, ctrl);
      end
    end
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if ({MemErr, ctrl} !== 8'b00000000) begin
      miscompares++;
      $display("[TB] FAIL err_reset: got err=%b ctrl=%b expected err=0 ctrl=0000000", MemErr, ctrl);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    test_reset();
    vectors++;
    if ({StallCnt, FlushCnt} !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL perf_reset: got S=%0d F=%0d expected 0 0", StallCnt, FlushCnt);
    end
    Match_12D_E = 1'b1; MemtoRegE = 1'b1; RegWriteE = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if ({StallCnt, FlushCnt} !== {4'd3, 4'd3}) begin
      miscompares++;
      $display("[TB] FAIL perf_count3: got S=%0d F=%0d expected 3 3", StallCnt, FlushCnt);
    end
    repeat (17) @(posedge clk);
    #2;
    vectors++;
    if ({StallCnt, FlushCnt} !== {4'd15, 4'd15}) begin
      miscompares++;
      $display("[TB] FAIL perf_saturate: got S=%0d F=%0d expected 15 15", StallCnt, FlushCnt);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_flush();
    test_mem_wait();
    test_ready_at_timeout();
    test_timeout_err();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
